// File: rtl/lab1_onchip_mem_arbiter.sv
// ---------------------------------------------------------------------------
// lab1_onchip_mem_arbiter
//
// Shares one single-port 1024 x 32 on-chip memory (s1 port, one-cycle read
// latency) between two Avalon-MM requesters. One command per cycle is driven
// onto the memory port. The losing requester is stalled with waitrequest, and
// returning read data is steered to the requester that issued the read.
//
// Handshake: a requester is active when read or write is high. A command is
// accepted in any cycle where the requester is active and its waitrequest is
// low. A stalled requester must hold its command until it is accepted. Read
// data for an accepted read is presented with readdatavalid exactly one cycle
// after the accepting cycle.
//
// Optional feature macro: LAB1_MEM_ARB_RR_EN
//   defined   -> round-robin on contention (the requester that is not
//                last_grant wins)
//   undefined -> fixed priority (requester 0 always wins)
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   mN_address/byteenable/
//   read/write/writedata       requester N command (N = 0, 1)
//   mN_waitrequest             requester N stall
//   mN_readdata/readdatavalid  requester N read return
//   mem_*                      memory s1 command port, mem_clken tied 1
//   mem_readdata               memory read data (one cycle after a read)
// ---------------------------------------------------------------------------
module lab1_onchip_mem_arbiter #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32,
  parameter int BE_W   = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] m0_address,
  input  logic [BE_W-1:0]   m0_byteenable,
  input  logic              m0_read,
  input  logic              m0_write,
  input  logic [DATA_W-1:0] m0_writedata,
  output logic              m0_waitrequest,
  output logic [DATA_W-1:0] m0_readdata,
  output logic              m0_readdatavalid,
  input  logic [ADDR_W-1:0] m1_address,
  input  logic [BE_W-1:0]   m1_byteenable,
  input  logic              m1_read,
  input  logic              m1_write,
  input  logic [DATA_W-1:0] m1_writedata,
  output logic              m1_waitrequest,
  output logic [DATA_W-1:0] m1_readdata,
  output logic              m1_readdatavalid,
  output logic [ADDR_W-1:0] mem_address,
  output logic [BE_W-1:0]   mem_byteenable,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_writedata,
  output logic              mem_clken,
  input  logic [DATA_W-1:0] mem_readdata
);

  logic active0;
  logic active1;
  logic grant0;
  logic grant1;
  logic any_grant;
  logic last_grant;  // index of the most recently granted requester
  logic rd_pend;     // a read was accepted last cycle
  logic rd_id;       // which requester issued that read

  assign active0   = m0_read | m0_write;
  assign active1   = m1_read | m1_write;
  assign any_grant = grant0 | grant1;

  // Grant selection. Nothing is granted while reset is asserted.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (!reset) begin
      if (active0 && active1) begin
`ifdef LAB1_MEM_ARB_RR_EN
        // last_grant == 1 means requester 1 went last, so requester 0 wins.
        grant0 = last_grant;
        grant1 = ~last_grant;
`else
        grant0 = 1'b1;
`endif
      end else begin
        grant0 = active0;
        grant1 = active1;
      end
    end
  end

  // Command mux. With no grant the requester-0 fields are passed through,
  // but chipselect and write stay low so the memory ignores them.
  always_comb begin
    mem_address    = m0_address;
    mem_byteenable = m0_byteenable;
    mem_writedata  = m0_writedata;
    mem_write      = grant0 & m0_write;
    if (grant1) begin
      mem_address    = m1_address;
      mem_byteenable = m1_byteenable;
      mem_writedata  = m1_writedata;
      mem_write      = m1_write;
    end
  end

  assign mem_chipselect = any_grant;
  assign mem_clken      = 1'b1;

  // Stall only an active requester that lost; everything stalls in reset.
  assign m0_waitrequest = reset | (active0 & ~grant0);
  assign m1_waitrequest = reset | (active1 & ~grant1);

  assign m0_readdata = mem_readdata;
  assign m1_readdata = mem_readdata;

  // Masking with reset drops a read whose return cycle collides with reset.
  assign m0_readdatavalid = rd_pend & ~rd_id & ~reset;
  assign m1_readdatavalid = rd_pend &  rd_id & ~reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant <= 1'b1;
      rd_pend    <= 1'b0;
      rd_id      <= 1'b0;
    end else begin
      last_grant <= any_grant ? grant1 : last_grant;
      // A read+write command is a write, so mem_write already excludes it.
      rd_pend    <= any_grant & ~mem_write;
      rd_id      <= grant1;
    end
  end

endmodule

// File: tb/tb_lab1_onchip_mem_arbiter.sv
// ---------------------------------------------------------------------------
// Testbench for lab1_onchip_mem_arbiter. Contains a behavioural model of the
// one-cycle-latency on-chip memory, a reference memory image, per-requester
// expected-data queues filled when reads are accepted and drained when
// readdatavalid is due, and one task per scenario.
// ---------------------------------------------------------------------------
module tb_lab1_onchip_mem_arbiter;

  localparam int ADDR_W = 10;
  localparam int DATA_W = 32;
  localparam int BE_W   = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [ADDR_W-1:0] m0_address, m1_address;
  logic [BE_W-1:0]   m0_byteenable, m1_byteenable;
  logic              m0_read, m0_write, m1_read, m1_write;
  logic [DATA_W-1:0] m0_writedata, m1_writedata;
  logic              m0_waitrequest, m1_waitrequest;
  logic [DATA_W-1:0] m0_readdata, m1_readdata;
  logic              m0_readdatavalid, m1_readdatavalid;
  logic [ADDR_W-1:0] mem_address;
  logic [BE_W-1:0]   mem_byteenable;
  logic              mem_chipselect, mem_write, mem_clken;
  logic [DATA_W-1:0] mem_writedata;
  logic [DATA_W-1:0] mem_readdata;

  int tests = 0;
  int fails = 0;

  lab1_onchip_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BE_W(BE_W)) dut (
    .clk(clk), .reset(reset),
    .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
    .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_waitrequest(m0_waitrequest),
    .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
    .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
    .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_waitrequest(m1_waitrequest),
    .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
    .mem_address(mem_address), .mem_byteenable(mem_byteenable),
    .mem_chipselect(mem_chipselect), .mem_write(mem_write),
    .mem_writedata(mem_writedata), .mem_clken(mem_clken),
    .mem_readdata(mem_readdata)
  );

  // ---------------- memory model (one-cycle read latency) ----------------
  logic [DATA_W-1:0] mem_arr [0:1023];
  always @(posedge clk) begin
    if (mem_chipselect && mem_clken) begin
      if (mem_write) begin
        for (int b = 0; b < BE_W; b++)
          if (mem_byteenable[b]) mem_arr[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
      end else begin
        mem_readdata <= mem_arr[mem_address];
      end
    end
  end

  // ---------------- scoreboard ----------------
  logic [DATA_W-1:0] ref_mem [0:1023];
  logic [DATA_W-1:0] exp_q0[$];
  logic [DATA_W-1:0] exp_q1[$];
  logic due0 = 1'b0;
  logic due1 = 1'b0;

  always @(negedge clk) begin
    logic acc0, acc1, ev0, ev1;
    logic [DATA_W-1:0] e;
    // read returns
    ev0 = due0 && !reset;
    ev1 = due1 && !reset;
    tests++;
    if (m0_readdatavalid !== ev0) begin
      fails++; $display("FAIL sb_m0_rdvalid: got %b expected %b", m0_readdatavalid, ev0);
    end
    tests++;
    if (m1_readdatavalid !== ev1) begin
      fails++; $display("FAIL sb_m1_rdvalid: got %b expected %b", m1_readdatavalid, ev1);
    end
    if (due0 && exp_q0.size() > 0) begin
      e = exp_q0.pop_front();
      if (ev0) begin
        tests++;
        if (m0_readdata !== e) begin
          fails++; $display("FAIL sb_m0_rddata: got %h expected %h", m0_readdata, e);
        end
      end
    end
    if (due1 && exp_q1.size() > 0) begin
      e = exp_q1.pop_front();
      if (ev1) begin
        tests++;
        if (m1_readdata !== e) begin
          fails++; $display("FAIL sb_m1_rddata: got %h expected %h", m1_readdata, e);
        end
      end
    end
    // command side
    if (reset) begin
      tests++;
      if (m0_waitrequest !== 1'b1 || m1_waitrequest !== 1'b1 || mem_chipselect !== 1'b0) begin
        fails++;
        $display("FAIL sb_reset_stall: got wr0=%b wr1=%b cs=%b expected 1 1 0",
                 m0_waitrequest, m1_waitrequest, mem_chipselect);
      end
    end else begin
      if (!(m0_read || m0_write)) begin
        tests++;
        if (m0_waitrequest !== 1'b0) begin
          fails++; $display("FAIL sb_m0_idle_wait: got %b expected 0", m0_waitrequest);
        end
      end
      if (!(m1_read || m1_write)) begin
        tests++;
        if (m1_waitrequest !== 1'b0) begin
          fails++; $display("FAIL sb_m1_idle_wait: got %b expected 0", m1_waitrequest);
        end
      end
      tests++;
      if (mem_chipselect !== (m0_read || m0_write || m1_read || m1_write)) begin
        fails++; $display("FAIL sb_chipselect: got %b expected %b", mem_chipselect,
                          (m0_read || m0_write || m1_read || m1_write));
      end
    end
    acc0 = !reset && (m0_read || m0_write) && (m0_waitrequest === 1'b0);
    acc1 = !reset && (m1_read || m1_write) && (m1_waitrequest === 1'b0);
    if (!reset && (m0_read || m0_write) && (m1_read || m1_write)) begin
      tests++;
      if (acc0 == acc1) begin
        fails++; $display("FAIL sb_one_grant: got acc0=%b acc1=%b expected exactly one", acc0, acc1);
      end
    end
    if (acc0 && !acc1) begin
      tests++;
      if (mem_address !== m0_address || mem_write !== m0_write ||
          (m0_write && (mem_byteenable !== m0_byteenable || mem_writedata !== m0_writedata))) begin
        fails++; $display("FAIL sb_m0_cmd: got a=%h w=%b expected a=%h w=%b",
                          mem_address, mem_write, m0_address, m0_write);
      end
      if (m0_write) begin
        for (int b = 0; b < BE_W; b++)
          if (m0_byteenable[b]) ref_mem[m0_address][8*b +: 8] = m0_writedata[8*b +: 8];
      end else exp_q0.push_back(ref_mem[m0_address]);
    end
    if (acc1 && !acc0) begin
      tests++;
      if (mem_address !== m1_address || mem_write !== m1_write ||
          (m1_write && (mem_byteenable !== m1_byteenable || mem_writedata !== m1_writedata))) begin
        fails++; $display("FAIL sb_m1_cmd: got a=%h w=%b expected a=%h w=%b",
                          mem_address, mem_write, m1_address, m1_write);
      end
      if (m1_write) begin
        for (int b = 0; b < BE_W; b++)
          if (m1_byteenable[b]) ref_mem[m1_address][8*b +: 8] = m1_writedata[8*b +: 8];
      end else exp_q1.push_back(ref_mem[m1_address]);
    end
    due0 = acc0 && !acc1 && m0_read && !m0_write;
    due1 = acc1 && !acc0 && m1_read && !m1_write;
  end

  // ---------------- driver tasks ----------------
  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic idle_all;
    m0_read = 0; m0_write = 0; m1_read = 0; m1_write = 0;
  endtask

  task automatic drive0(input logic rd, input logic wr, input logic [ADDR_W-1:0] a,
                        input logic [BE_W-1:0] be, input logic [DATA_W-1:0] d);
    m0_read = rd; m0_write = wr; m0_address = a; m0_byteenable = be; m0_writedata = d;
  endtask

  task automatic drive1(input logic rd, input logic wr, input logic [ADDR_W-1:0] a,
                        input logic [BE_W-1:0] be, input logic [DATA_W-1:0] d);
    m1_read = rd; m1_write = wr; m1_address = a; m1_byteenable = be; m1_writedata = d;
  endtask

  task automatic pulse_reset;
    tick; idle_all; reset = 1;
    tick; reset = 0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset;
    tick;
    drive0(1, 0, 10'd3, 4'hF, 0);
    drive1(1, 0, 10'd4, 4'hF, 0);
    @(negedge clk);
    tests++;
    if (m0_waitrequest !== 1'b1 || m1_waitrequest !== 1'b1) begin
      fails++; $display("FAIL reset_wait: got %b %b expected 1 1", m0_waitrequest, m1_waitrequest);
    end
    tests++;
    if (mem_chipselect !== 1'b0 || m0_readdatavalid !== 1'b0 || m1_readdatavalid !== 1'b0) begin
      fails++; $display("FAIL reset_outputs: got cs=%b v0=%b v1=%b expected 0 0 0",
                        mem_chipselect, m0_readdatavalid, m1_readdatavalid);
    end
    tick; idle_all; reset = 0;
    @(negedge clk);
    tests++;
    if (m0_readdatavalid !== 1'b0 || m1_readdatavalid !== 1'b0) begin
      fails++; $display("FAIL reset_after_valid: got %b %b expected 0 0", m0_readdatavalid, m1_readdatavalid);
    end
  endtask

  task automatic test_isolated;
    tick; drive0(0, 1, 10'd5, 4'hF, 32'hDEADBEEF);
    @(negedge clk);
    tests++;
    if (m0_waitrequest !== 1'b0 || mem_write !== 1'b1) begin
      fails++; $display("FAIL iso_write: got wr=%b mw=%b expected 0 1", m0_waitrequest, mem_write);
    end
    tick; drive0(1, 0, 10'd5, 4'hF, 0);
    @(negedge clk);
    tests++;
    if (m0_waitrequest !== 1'b0 || m0_readdatavalid !== 1'b0) begin
      fails++; $display("FAIL iso_read_cmd: got wr=%b v=%b expected 0 0", m0_waitrequest, m0_readdatavalid);
    end
    tick; idle_all;
    @(negedge clk);
    tests++;
    if (m0_readdatavalid !== 1'b1 || m0_readdata !== 32'hDEADBEEF || m1_readdatavalid !== 1'b0) begin
      fails++; $display("FAIL iso_read_data: got v0=%b d=%h v1=%b expected 1 deadbeef 0",
                        m0_readdatavalid, m0_readdata, m1_readdatavalid);
    end
    tick;
  endtask

  task automatic test_byte_enables;
    tick; drive0(0, 1, 10'd7, 4'hF, 32'h11223344);
    tick; idle_all; drive1(0, 1, 10'd7, 4'h5, 32'hAABBCCDD);
    tick; idle_all; drive1(1, 0, 10'd7, 4'hF, 0);
    tick; idle_all; drive0(1, 0, 10'd7, 4'hF, 0);
    @(negedge clk);
    tests++;
    if (m1_readdatavalid !== 1'b1 || m1_readdata !== 32'h11BB33DD) begin
      fails++; $display("FAIL be_m1_read: got v=%b d=%h expected 1 11bb33dd", m1_readdatavalid, m1_readdata);
    end
    tick; idle_all;
    @(negedge clk);
    tests++;
    if (m0_readdatavalid !== 1'b1 || m0_readdata !== 32'h11BB33DD) begin
      fails++; $display("FAIL be_m0_read: got v=%b d=%h expected 1 11bb33dd", m0_readdatavalid, m0_readdata);
    end
    tick;
  endtask

`ifdef LAB1_MEM_ARB_RR_EN
  task automatic test_contention;
    tick; drive0(0, 1, 10'd1, 4'hF, 32'h0101A0A0);
    tick; idle_all; drive1(0, 1, 10'd2, 4'hF, 32'h0202B0B0);
    tick; idle_all;
    pulse_reset;
    drive0(1, 0, 10'd1, 4'hF, 0);
    drive1(1, 0, 10'd2, 4'hF, 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      tests++;
      if (m0_waitrequest !== logic'(i % 2) || m1_waitrequest !== logic'((i + 1) % 2)) begin
        fails++; $display("FAIL rr_grant_%0d: got wr0=%b wr1=%b expected %0d %0d",
                          i, m0_waitrequest, m1_waitrequest, i % 2, (i + 1) % 2);
      end
      if (i > 0) begin
        tests++;
        if ((i % 2 == 1 && (m0_readdatavalid !== 1'b1 || m0_readdata !== 32'h0101A0A0)) ||
            (i % 2 == 0 && (m1_readdatavalid !== 1'b1 || m1_readdata !== 32'h0202B0B0))) begin
          fails++; $display("FAIL rr_return_%0d: got v0=%b v1=%b d=%h", i,
                            m0_readdatavalid, m1_readdatavalid, mem_readdata);
        end
      end
      tick;
    end
    idle_all;
    tick;
  endtask
`else
  task automatic test_contention;
    tick;
    drive0(0, 1, 10'd20, 4'hF, 32'hC0DE0020);
    drive1(0, 1, 10'd21, 4'hF, 32'hC0DE0021);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      tests++;
      if (m1_waitrequest !== 1'b1 || m0_waitrequest !== 1'b0) begin
        fails++; $display("FAIL fixed_stall_%0d: got wr0=%b wr1=%b expected 0 1",
                          i, m0_waitrequest, m1_waitrequest);
      end
      tick;
    end
    m0_write = 0;
    @(negedge clk);
    tests++;
    if (m1_waitrequest !== 1'b0 || mem_address !== 10'd21) begin
      fails++; $display("FAIL fixed_release: got wr1=%b a=%h expected 0 015", m1_waitrequest, mem_address);
    end
    tick; idle_all;
    tick;
  endtask
`endif

  task automatic test_reset_mid_read;
    tick; drive1(1, 0, 10'd7, 4'hF, 0);
    @(negedge clk);
    tests++;
    if (m1_waitrequest !== 1'b0) begin
      fails++; $display("FAIL rmr_accept: got %b expected 0", m1_waitrequest);
    end
    tick; reset = 1;
    drive0(1, 0, 10'd5, 4'hF, 0);
    drive1(1, 0, 10'd7, 4'hF, 0);
    @(negedge clk);
    tests++;
    if (m0_readdatavalid !== 1'b0 || m1_readdatavalid !== 1'b0 ||
        m0_waitrequest !== 1'b1 || m1_waitrequest !== 1'b1) begin
      fails++; $display("FAIL rmr_in_reset: got v0=%b v1=%b wr0=%b wr1=%b expected 0 0 1 1",
                        m0_readdatavalid, m1_readdatavalid, m0_waitrequest, m1_waitrequest);
    end
    tick; reset = 0;
    @(negedge clk);
    tests++;
    if (m0_waitrequest !== 1'b0 || m1_waitrequest !== 1'b1 || m1_readdatavalid !== 1'b0) begin
      fails++; $display("FAIL rmr_first_contention: got wr0=%b wr1=%b v1=%b expected 0 1 0",
                        m0_waitrequest, m1_waitrequest, m1_readdatavalid);
    end
    tick; idle_all;
    tick;
  endtask

  task automatic test_read_write_same;
    tick; drive0(1, 1, 10'd9, 4'hF, 32'h5A5A5A5A);
    @(negedge clk);
    tests++;
    if (m0_waitrequest !== 1'b0 || mem_write !== 1'b1) begin
      fails++; $display("FAIL rw_write: got wr=%b mw=%b expected 0 1", m0_waitrequest, mem_write);
    end
    tick; idle_all;
    @(negedge clk);
    tests++;
    if (m0_readdatavalid !== 1'b0) begin
      fails++; $display("FAIL rw_no_valid: got %b expected 0", m0_readdatavalid);
    end
    tick; drive0(1, 0, 10'd9, 4'hF, 0);
    tick; idle_all;
    @(negedge clk);
    tests++;
    if (m0_readdata !== 32'h5A5A5A5A || m0_readdatavalid !== 1'b1) begin
      fails++; $display("FAIL rw_readback: got v=%b d=%h expected 1 5a5a5a5a", m0_readdatavalid, m0_readdata);
    end
    tick;
  endtask

  task automatic test_back_to_back;
    logic [ADDR_W-1:0] base;
    logic [DATA_W-1:0] data [4];
    base = ADDR_W'($urandom_range(100, 1000));
    for (int i = 0; i < 4; i++) begin
      data[i] = $urandom;
      tick; drive1(0, 1, base + ADDR_W'(i), 4'hF, data[i]);
      @(negedge clk);
      tests++;
      if (m1_waitrequest !== 1'b0 || m0_waitrequest !== 1'b0) begin
        fails++; $display("FAIL b2b_write_%0d: got wr1=%b wr0=%b expected 0 0", i, m1_waitrequest, m0_waitrequest);
      end
    end
    tick; idle_all;
    for (int i = 0; i < 5; i++) begin
      if (i < 4) drive0(1, 0, base + ADDR_W'(i), 4'hF, 0);
      else idle_all;
      @(negedge clk);
      if (i < 4) begin
        tests++;
        if (m0_waitrequest !== 1'b0) begin
          fails++; $display("FAIL b2b_read_wait_%0d: got %b expected 0", i, m0_waitrequest);
        end
      end
      if (i > 0) begin
        tests++;
        if (m0_readdatavalid !== 1'b1 || m0_readdata !== data[i-1]) begin
          fails++; $display("FAIL b2b_read_data_%0d: got v=%b d=%h expected 1 %h",
                            i - 1, m0_readdatavalid, m0_readdata, data[i-1]);
        end
      end
      tick;
    end
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    idle_all;
    m0_address = 0; m0_byteenable = 0; m0_writedata = 0;
    m1_address = 0; m1_byteenable = 0; m1_writedata = 0;
    reset = 1;
    repeat (2) @(posedge clk);
    test_reset;
    test_isolated;
    test_byte_enables;
    test_contention;
    test_reset_mid_read;
    test_read_write_same;
    test_back_to_back;
    repeat (2) tick;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
